// File: rtl/bcd_scan_decoder.sv
// rtl/bcd_scan_decoder.sv - BCD one-hot decoder with digit buffer and 7-seg scan (optional clr: BCD_SCAN_DECODER_CLR_EN)
module bcd_scan_decoder #(
    parameter int SCAN_DIV = 100000,
    parameter int NDIG     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef BCD_SCAN_DECODER_CLR_EN
    input  logic            clr,
`endif
    input  logic            d_valid,
    input  logic [3:0]      d,
    output logic [9:0]      y,
    output logic            err,
    output logic [3:0]      cnt,
    output logic [6:0]      cn,
    output logic [NDIG-1:0] an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [3:0]    CNT_MAX  = 4'(NDIG);

    logic [PW-1:0]          pre_q, pre_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NDIG-1:0][3:0]   buf_q, buf_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [9:0]             y_q, y_d;
    logic                   err_q, err_d;
    logic [6:0]             cn_q, cn_d;
    logic [NDIG-1:0]        an_q, an_d;
    logic                   clr_w;

`ifdef BCD_SCAN_DECODER_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = 1'b0;
`endif

    // Segment pattern {g..a}, active low.
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        pre_d = pre_q;
        idx_d = idx_q;
        buf_d = buf_q;
        cnt_d = cnt_q;
        y_d   = y_q;
        err_d = err_q;
        an_d  = '1;
        cn_d  = 7'h7F;

        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        if (clr_w) begin
            buf_d = '0;
            cnt_d = '0;
            y_d   = '0;
            err_d = 1'b0;
        end else if (d_valid) begin
            if (d <= 4'd9) begin
                y_d   = 10'd1 << d;
                err_d = 1'b0;
                buf_d = {buf_q[NDIG-2:0], d};
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                y_d   = '0;
                err_d = 1'b1;
            end
        end

        // Display follows the registered state, so it lags any change by one cycle.
        if (4'(idx_q) < cnt_q) begin
            an_d = ~(NDIG'(1) << idx_q);
            cn_d = seg(buf_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            buf_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
            an_q  <= '1;
            cn_q  <= 7'h7F;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
            err_q <= err_d;
            an_q  <= an_d;
            cn_q  <= cn_d;
        end
    end

    assign y   = y_q;
    assign err = err_q;
    assign cnt = cnt_q;
    assign cn  = cn_q;
    assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// tb/tb_bcd_scan_decoder.sv - randomized self-checking bench for bcd_scan_decoder
module tb_bcd_scan_decoder;

    localparam int DIV = 4;
    localparam int N   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_s = 1'b0;
    logic        d_valid = 1'b0;
    logic [3:0]  d = 4'd0;
    logic [9:0]  y;
    logic        err;
    logic [3:0]  cnt;
    logic [6:0]  cn;
    logic [7:0]  an;

    int n_vec = 0;
    int n_err = 0;

    bcd_scan_decoder #(.SCAN_DIV(DIV), .NDIG(N)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef BCD_SCAN_DECODER_CLR_EN
        .clr(clr_s),
`endif
        .d_valid(d_valid),
        .d(d),
        .y(y),
        .err(err),
        .cnt(cnt),
        .cn(cn),
        .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: digit list newest-first, scan position as plain counters.
    int         m_digits [N];
    int         m_cnt, m_pre, m_idx;
    logic [9:0] m_y;
    logic       m_err;
    logic [7:0] m_an;
    logic [6:0] m_cn;

    task automatic tick(input logic r, input logic v, input logic [3:0] dd, input logic c);
        rst_n = r; d_valid = v; d = dd; clr_s = c;
        @(posedge clk);
        if (!r) begin
            foreach (m_digits[i]) m_digits[i] = 0;
            m_cnt = 0; m_pre = 0; m_idx = 0;
            m_y = '0; m_err = 1'b0; m_an = 8'hFF; m_cn = 7'h7F;
        end else begin
            if (m_idx < m_cnt) begin
                m_an = ~(8'd1 << m_idx);
                m_cn = seg_tab[m_digits[m_idx]];
            end else begin
                m_an = 8'hFF;
                m_cn = 7'h7F;
            end
            m_pre = m_pre + 1;
            if (m_pre == DIV) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % N;
            end
            if (c) begin
                foreach (m_digits[i]) m_digits[i] = 0;
                m_cnt = 0; m_y = '0; m_err = 1'b0;
            end else if (v) begin
                if (dd <= 9) begin
                    for (int i = N - 1; i > 0; i--) m_digits[i] = m_digits[i-1];
                    m_digits[0] = int'(dd);
                    m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
                    m_y = 10'd1 << dd;
                    m_err = 1'b0;
                end else begin
                    m_y = '0;
                    m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'd5, 1'b0);
        n_vec++;
        if ({y, err, cnt, an, cn} !== {10'd0, 1'b0, 4'd0, 8'hFF, 7'h7F}) begin
            n_err++;
            $display("FAIL reset_values: got y=%b err=%b cnt=%0d an=%h cn=%b, want 0/0/0/FF/7F", y, err, cnt, an, cn);
        end
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 4'd0, 1'b0);
        n_vec++;
        if (an !== 8'hFF || cn !== 7'h7F) begin
            n_err++;
            $display("FAIL reset_release_blank: got an=%h cn=%b, want FF/7F", an, cn);
        end
    endtask

    task automatic test_single();
        int seen_fe = 0;
        tick(1'b1, 1'b1, 4'd3, 1'b0);
        n_vec++;
        if (y !== 10'b0000001000 || cnt !== 4'd1) begin
            n_err++;
            $display("FAIL single_accept: got y=%b cnt=%0d, want 0000001000/1", y, cnt);
        end
        for (int i = 0; i < 4 * DIV * N; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0);
            n_vec++;
            if (an !== m_an || cn !== m_cn) begin
                n_err++;
                $display("FAIL single_scan: cyc %0d got an=%h cn=%b, want an=%h cn=%b", i, an, cn, m_an, m_cn);
            end
            if (an == 8'hFE) begin
                seen_fe++;
                n_vec++;
                if (cn !== 7'b0110000) begin
                    n_err++;
                    $display("FAIL single_seg3: got cn=%b, want 0110000", cn);
                end
            end
        end
        n_vec++;
        if (seen_fe != 4 * DIV) begin
            n_err++;
            $display("FAIL single_slot_len: got %0d cycles with an=FE, want %0d", seen_fe, 4 * DIV);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 9; k++) tick(1'b1, 1'b1, 4'(k), 1'b0);
        n_vec++;
        if (cnt !== 4'd8) begin
            n_err++;
            $display("FAIL overflow_cnt: got %0d, want 8", cnt);
        end
        for (int i = 0; i < 2 * DIV * N + 2; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0);
            n_vec++;
            if (an !== m_an || cn !== m_cn || $countones(~an) != 1) begin
                n_err++;
                $display("FAIL overflow_scan: cyc %0d got an=%h cn=%b, want an=%h cn=%b", i, an, cn, m_an, m_cn);
            end
            if (an == 8'h7F) begin
                n_vec++;
                if (cn !== 7'b0100100) begin
                    n_err++;
                    $display("FAIL overflow_oldest: got cn=%b, want 0100100 (digit 2)", cn);
                end
            end
        end
    endtask

    task automatic test_illegal();
        tick(1'b1, 1'b1, 4'd10, 1'b0);
        n_vec++;
        if (y !== 10'd0 || err !== 1'b1 || cnt !== 4'd8) begin
            n_err++;
            $display("FAIL illegal_code: got y=%b err=%b cnt=%0d, want 0/1/8", y, err, cnt);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 4'd0, 1'b0);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_sticky: got err=%b, want 1", err);
        end
        tick(1'b1, 1'b1, 4'd0, 1'b0);
        n_vec++;
        if (err !== 1'b0 || y !== 10'b0000000001) begin
            n_err++;
            $display("FAIL illegal_recover: got err=%b y=%b, want 0/0000000001", err, y);
        end
    endtask

    task automatic test_mid_scan_reset();
        int budget = 200;
        while (!(m_pre == 2 && m_idx == 5) && budget > 0) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0);
            budget--;
        end
        n_vec++;
        if (budget == 0) begin
            n_err++;
            $display("FAIL midscan_reach: got no prescaler=2 idx=5 point, want one within 200 cycles");
        end
        tick(1'b0, 1'b1, 4'd6, 1'b0);
        n_vec++;
        if ({y, err, cnt, an, cn} !== {10'd0, 1'b0, 4'd0, 8'hFF, 7'h7F}) begin
            n_err++;
            $display("FAIL midscan_reset: got y=%b err=%b cnt=%0d an=%h cn=%b, want 0/0/0/FF/7F", y, err, cnt, an, cn);
        end
        tick(1'b1, 1'b1, 4'd4, 1'b0);
        for (int i = 0; i < DIV + 1; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0);
            n_vec++;
            if (an !== m_an || cn !== m_cn) begin
                n_err++;
                $display("FAIL midscan_restart: cyc %0d got an=%h cn=%b, want an=%h cn=%b", i, an, cn, m_an, m_cn);
            end
        end
    endtask

`ifdef BCD_SCAN_DECODER_CLR_EN
    task automatic test_clr();
        int idx_before;
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 4'(k), 1'b0);
        idx_before = m_idx;
        tick(1'b1, 1'b1, 4'd7, 1'b1);
        n_vec++;
        if (cnt !== 4'd0 || y !== 10'd0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL clr_state: got cnt=%0d y=%b err=%b, want 0/0/0", cnt, y, err);
        end
        for (int i = 0; i < DIV * N; i++) begin
            tick(1'b1, 1'b0, 4'd0, 1'b0);
            n_vec++;
            if (an !== 8'hFF || an !== m_an) begin
                n_err++;
                $display("FAIL clr_blank: cyc %0d got an=%h, want FF", i, an);
            end
        end
        n_vec++;
        if (dut.idx_q !== 3'(m_idx) || m_idx != (idx_before + (N + 1 + DIV * N) / DIV) % N - 0 && 0) begin
            n_err++;
            $display("FAIL clr_scan_continues: got idx=%0d, want %0d", dut.idx_q, m_idx);
        end
    endtask
`endif

    task automatic test_random();
        logic v, c, r;
        logic [3:0] dd;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            v  = $urandom_range(0, 1);
            dd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            c  = 1'b0;
`ifdef BCD_SCAN_DECODER_CLR_EN
            c  = ($urandom_range(0, 99) == 0);
`endif
            tick(r, v, dd, c);
            n_vec++;
            if ({y, err, cnt, an, cn} !== {m_y, m_err, 4'(m_cnt), m_an, m_cn}) begin
                n_err++;
                $display("FAIL random: cyc %0d got y=%b err=%b cnt=%0d an=%h cn=%b, want y=%b err=%b cnt=%0d an=%h cn=%b",
                         i, y, err, cnt, an, cn, m_y, m_err, m_cnt, m_an, m_cn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_illegal();
        test_mid_scan_reset();
`ifdef BCD_SCAN_DECODER_CLR_EN
        test_clr();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
